aes_inv_key_exp: RTL and testbench

Inverse AES-128 key expansion engine for the decryption datapath. It is loaded with the final (round 10) round key and walks the key schedule backwards, presenting one round key per accepted handshake: round 10 first, round 0 (the cipher key) last. It generates the inverse round-constant sequence internally (0x36, 0x1b, 0x80 … 0x01) and feeds the inverse cipher's AddRoundKey stage.

---
 rtl/aes_inv_key_exp.sv | 149 ++++++++++++++
 tb/tb_aes_inv_key_exp.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_exp.sv
// aes_inv_key_exp: inverse AES-128 key schedule.
//   Loaded with the round-10 key, presents round keys 10..0, one per
//   accepted rk_valid/rk_ready handshake, then pulses done.
// Ports:
//   clk, rst (async, active-low)
//   kld, key_in[127:0]      - load strobe / round-10 key (word 0 in [127:96])
//   rk_ready                - consumer accepts rk
//   rk[127:0], rnd[3:0]     - current round key and its round index
//   rk_valid, busy, done    - key valid, schedule running, completion pulse
// Build option:
//   AES_INV_KEY_CLR_EN - when defined, rk reads as zero whenever rk_valid is low.

// Combinational AES S-box: multiplicative inverse in GF(2^8) (as a^254)
// followed by the affine transform. Avoids a 256-entry table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  always_comb begin
    x2   = gf_mul(a, a);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    // a^254 = a^(2+4+8+16+32+64+128); maps 0 to 0 as the S-box requires
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    s    = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end
endmodule

module aes_inv_key_exp (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rnd,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [31:0]  rot_w, sub_w;
  logic         accept;

  // Undo the forward recurrence: previous words recovered by XOR of neighbours,
  // then w0 needs g() of the recovered previous w3.
  assign w0   = rk_q[127:96];
  assign w1   = rk_q[95:64];
  assign w2   = rk_q[63:32];
  assign w3   = rk_q[31:0];
  assign w3_n = w3 ^ w2;
  assign w2_n = w2 ^ w1;
  assign w1_n = w1 ^ w0;
  assign rot_w = {w3_n[23:0], w3_n[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[g*8 +: 8]), .s(sub_w[g*8 +: 8]));
  end

  assign w0_n = w0 ^ sub_w ^ {rcon_q, 24'h0};

  assign accept = (state_q == RUN) && rk_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    if (kld) begin
      state_d = RUN;
      rk_d    = key_in;
      rnd_d   = 4'd10;
      rcon_d  = 8'h36;
    end else if (accept) begin
      if (rnd_q != 4'd0) begin
        rk_d  = {w0_n, w1_n, w2_n, w3_n};
        rnd_d = rnd_q - 4'd1;
        // Inverse xtime walks 0x36,0x1b,0x80,...,0x01; stop at 0x01
        if (rcon_q != 8'h01)
          rcon_d = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80) : (rcon_q >> 1);
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      rnd_q   <= '0;
      rcon_q  <= 8'h36;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // rk_valid and busy are both exactly "schedule running"
  assign rk_valid = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign rnd      = rnd_q;

`ifdef AES_INV_KEY_CLR_EN
  assign rk = rk_valid ? rk_q : '0;
`else
  assign rk = rk_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_exp.sv
module tb_aes_inv_key_exp;
  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rnd;
  logic         rk_valid, busy, done;

  aes_inv_key_exp dut (
    .clk(clk), .rst(rst), .kld(kld), .key_in(key_in), .rk_ready(rk_ready),
    .rk(rk), .rnd(rnd), .rk_valid(rk_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad   = 0;
  int           done_cnt = 0;
  logic         done_exp = 1'b0;
  logic [127:0] idle_rk = '0;
  logic [127:0] got_key [11];
  logic [127:0] ref_key [11];
  logic [7:0]   sb [256];
  logic [7:0]   rc [11];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] rl(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box by walking the multiplicative group with generator 3 and its inverse
  function automatic void build_tables();
    logic [7:0] p, qq, x;
    p = 8'h01; qq = 8'h01;
    do begin
      p  = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ (qq << 1);
      qq = qq ^ (qq << 2);
      qq = qq ^ (qq << 4);
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ rl(qq, 1) ^ rl(qq, 2) ^ rl(qq, 3) ^ rl(qq, 4) ^ 8'h63;
      sb[p] = x;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++)
      rc[i] = (rc[i-1] << 1) ^ (rc[i-1][7] ? 8'h1b : 8'h00);
  endfunction

  // Reconstruct the whole FIPS-197 word array backwards from the last four words
  function automatic void push_schedule(logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    q.delete();
    for (int r = 10; r >= 0; r--) begin
      exp_t e;
      e.rnd = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      q.push_back(e);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      done_exp = 1'b0;
    end else begin
      chk("done", done, done_exp);
      if (done) done_cnt++;
      done_exp = 1'b0;
      if (!kld) begin
        chk("rk_valid", rk_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        if (q.size() != 0) begin
          chk("rnd", rnd, q[0].rnd);
          chk("rk", rk, q[0].key);
          if (rk_ready) begin
            got_key[q[0].rnd] = rk;
            if (q[0].rnd == 4'd0) begin
              done_exp = 1'b1;
`ifdef AES_INV_KEY_CLR_EN
              idle_rk = '0;
`else
              idle_rk = q[0].key;
`endif
            end
            void'(q.pop_front());
          end
        end else begin
          chk("idle_rk", rk, idle_rk);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_load(logic [127:0] k);
    kld = 1'b1;
    key_in = k;
    push_schedule(k);
    cyc();
    kld = 1'b0;
  endtask

  task automatic drain(int mode);
    int i;
    for (i = 0; i < 300 && q.size() != 0; i++) begin
      if (mode == 0) rk_ready = 1'b1;
      else if (mode == 1) rk_ready = (i % 3 == 0);
      else rk_ready = ($urandom_range(3) != 0);
      cyc();
    end
    chk("drain_timeout", q.size(), 0);
    rk_ready = 1'b1;
    cyc(); cyc();
  endtask

  initial begin
    logic [127:0] k;
    build_tables();
    rst = 1'b0; kld = 1'b0; key_in = '0; rk_ready = 1'b0;
    #2;
    chk("rst_rk", rk, 0);
    chk("rst_rnd", rnd, 0);
    chk("rst_valid", rk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    cyc();
    rst = 1'b1;
    rk_ready = 1'b1;
    cyc(); cyc();

    // FIPS-197 A.1 with full throughput
    done_cnt = 0;
    for (int r = 0; r < 11; r++) got_key[r] = '0;
    do_load(FIPS_K10);
    drain(0);
    chk("fips_k10", got_key[10], FIPS_K10);
    chk("fips_k9", got_key[9], FIPS_K9);
    chk("fips_k0", got_key[0], FIPS_K0);
`ifdef AES_INV_KEY_CLR_EN
    chk("cfg_rk_after_done", rk, 0);
`else
    chk("cfg_rk_after_done", rk, FIPS_K0);
`endif
    chk("fips_done_cnt", done_cnt, 1);
    for (int r = 0; r < 11; r++) ref_key[r] = got_key[r];

    // Backpressure, ready pattern 1,0,0,1,...
    done_cnt = 0;
    for (int r = 0; r < 11; r++) got_key[r] = '0;
    do_load(FIPS_K10);
    drain(1);
    for (int r = 0; r < 11; r++) chk("bp_seq", got_key[r], ref_key[r]);
    chk("bp_done_cnt", done_cnt, 1);

    // Restart at rnd=5 with a simultaneous accept
    rk_ready = 1'b1;
    do_load(FIPS_K10);
    repeat (5) cyc();
    chk("pre_restart_rnd", rnd, 5);
    k = {$urandom, $urandom, $urandom, $urandom};
    do_load(k);
    chk("restart_rnd", rnd, 10);
    chk("restart_rk", rk, k);
    drain(0);

    // kld coincident with final acceptance: load wins, no done
    done_cnt = 0;
    do_load(FIPS_K10);
    repeat (10) cyc();
    chk("pre_final_rnd", rnd, 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    do_load(k);
    chk("final_kld_done", done, 0);
    drain(0);
    chk("final_kld_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-schedule at rnd=6
    do_load(FIPS_K10);
    repeat (4) cyc();
    chk("pre_rst_rnd", rnd, 6);
    #2;
    q.delete();
    idle_rk = '0;
    rst = 1'b0;
    #1;
    chk("arst_valid", rk_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rk", rk, 0);
    cyc();
    rst = 1'b1;
    rk_ready = 1'b1;
    repeat (4) cyc();
    chk("post_rst_valid", rk_valid, 0);

    // Random keys, random backpressure, occasional restarts
    for (int n = 0; n < 16; n++) begin
      do_load({$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(10)) begin
          rk_ready = $urandom_range(1);
          cyc();
        end
        do_load({$urandom, $urandom, $urandom, $urandom});
      end
      drain(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
